// File: rtl/dsp_result_packer_if.sv
// Handshake bundle between the DSP result packer, the tap sequencer and the pixel writer.
// The master side drives results and the ready signal; the slave side is the packer itself.
interface dsp_result_packer_if #(
  parameter int PW    = 24,
  parameter int OW    = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic signed [PW-1:0] p_in;
  logic                 p_valid;
  logic [OW-1:0]        dout;
  logic                 dout_valid;
  logic                 dout_ready;
  logic                 almost_full;
  logic [CW-1:0]        count;
  logic                 overflow;

  modport master (
    output p_in, p_valid, dout_ready,
    input  dout, dout_valid, almost_full, count, overflow
  );

  modport slave (
    input  p_in, p_valid, dout_ready,
    output dout, dout_valid, almost_full, count, overflow
  );
endinterface

// File: rtl/dsp_result_packer.sv
// Rounds, rescales and clamps finished DSP accumulations into pixels, then queues them in a FWFT FIFO.
// Build option DSP_PACK_SIGNED_EN selects a two's-complement clamp instead of the unsigned one.
module dsp_result_packer #(
  parameter int PW           = 24,
  parameter int OW           = 8,
  parameter int SHIFT        = 7,
  parameter int DEPTH        = 16,
  parameter int AFULL_MARGIN = 6
) (
  input logic               clk,
  input logic               rst,
  dsp_result_packer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic signed [PW:0] HALF     = (PW+1)'(1) << (SHIFT - 1);
  localparam logic [CW-1:0]      FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]      AFULL_TH = CW'(DEPTH - AFULL_MARGIN);
`ifdef DSP_PACK_SIGNED_EN
  localparam logic signed [PW:0] SMAX = (PW+1)'((2 ** (OW - 1)) - 1);
  localparam logic signed [PW:0] SMIN = -SMAX - (PW+1)'(1);
`else
  localparam logic signed [PW:0] UMAX = (PW+1)'((2 ** OW) - 1);
`endif

  // One guard bit keeps the rounding offset from wrapping at the positive extreme.
  function automatic logic signed [PW:0] round_shift(input logic signed [PW-1:0] p);
    logic signed [PW:0] sum;
    sum = $signed({p[PW-1], p}) + HALF;
    return sum >>> SHIFT;
  endfunction

  function automatic logic [OW-1:0] sat(input logic signed [PW:0] r);
`ifdef DSP_PACK_SIGNED_EN
    if (r < SMIN)      return {1'b1, {(OW-1){1'b0}}};
    else if (r > SMAX) return {1'b0, {(OW-1){1'b1}}};
    else               return r[OW-1:0];
`else
    if (r[PW])         return '0;
    else if (r > UMAX) return '1;
    else               return r[OW-1:0];
`endif
  endfunction

  logic signed [PW:0] r_p1_q;
  logic               vld_p1_q;
  logic [OW-1:0]      px_p2_q;
  logic               vld_p2_q;

  // Stage 1: round and rescale; Stage 2: clamp to pixel range.
  always_ff @(posedge clk) begin
    r_p1_q  <= round_shift(bus.p_in);
    px_p2_q <= sat(r_p1_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p1_q <= bus.p_valid;
      vld_p2_q <= vld_p1_q;
    end
  end

  // FIFO stage: push from stage 2, pop on the output handshake.
  logic [OW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [OW-1:0] last_q;
  logic          ovf_q, afull_q;
  logic          empty, full, pop, push, drop;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == FULL_CNT);
    pop     = !empty && bus.dout_ready;
    push    = vld_p2_q && (!full || pop);
    drop    = vld_p2_q && full && !pop;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= px_p2_q;
  end

  // last_q keeps the popped word visible once the FIFO drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
      ovf_q    <= 1'b0;
      afull_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= mem_q[rd_ptr_q];
      end
      if (drop) ovf_q <= 1'b1;
      count_q <= count_d;
      afull_q <= (count_d >= AFULL_TH);
    end
  end

  assign bus.dout        = empty ? last_q : mem_q[rd_ptr_q];
  assign bus.dout_valid  = !empty;
  assign bus.count       = count_q;
  assign bus.overflow    = ovf_q;
  assign bus.almost_full = afull_q;
endmodule

// File: tb/tb_dsp_result_packer.sv
// Bench for dsp_result_packer: directed rounding/clamp/FIFO scenarios plus randomized traffic,
// all checked every cycle against a queue-based model of the packer's rules.
module tb_dsp_result_packer;
  localparam int PW    = 24;
  localparam int OW    = 8;
  localparam int SHIFT = 7;
  localparam int DEPTH = 16;
  localparam int AFM   = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dsp_result_packer_if #(.PW(PW), .OW(OW), .DEPTH(DEPTH)) bus();

  dsp_result_packer #(
    .PW(PW), .OW(OW), .SHIFT(SHIFT), .DEPTH(DEPTH), .AFULL_MARGIN(AFM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference state: pixel queue, last popped pixel, sticky drop flag, two in-flight slots.
  int mq[$];
  int m_last;
  bit m_ovf;
  bit d1v, d2v;
  int d1x, d2x;

  function automatic int ref_pixel(int p);
    longint t, q, d;
    d = longint'(1) << SHIFT;
    t = longint'(p) + d / 2;
    q = t / d;
    if ((t % d != 0) && (t < 0)) q = q - 1;
`ifdef DSP_PACK_SIGNED_EN
    if (q < -(longint'(1) << (OW - 1)))     q = -(longint'(1) << (OW - 1));
    if (q > (longint'(1) << (OW - 1)) - 1)  q = (longint'(1) << (OW - 1)) - 1;
`else
    if (q < 0)                        q = 0;
    if (q > (longint'(1) << OW) - 1)  q = (longint'(1) << OW) - 1;
`endif
    return int'(q);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    m_last = 0; m_ovf = 1'b0; d1v = 1'b0; d2v = 1'b0; d1x = 0; d2x = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        m_last = 0; m_ovf = 1'b0; d1v = 1'b0; d2v = 1'b0;
      end else begin
        if (mq.size() > 0 && bus.dout_ready) m_last = mq.pop_front();
        if (d2v) begin
          if (mq.size() < DEPTH) mq.push_back(d2x);
          else                   m_ovf = 1'b1;
        end
        d2v = d1v; d2x = d1x;
        d1v = bus.p_valid;
        d1x = ref_pixel(int'(bus.p_in));
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        int e;
        e = (mq.size() > 0) ? mq[0] : m_last;
        check("dout_valid", int'(bus.dout_valid), int'(mq.size() > 0));
        check("dout", int'(bus.dout), e & ((1 << OW) - 1));
        check("count", int'(bus.count), mq.size());
        check("overflow", int'(bus.overflow), int'(m_ovf));
        check("almost_full", int'(bus.almost_full), int'(mq.size() >= DEPTH - AFM));
      end
    end
  end

  task automatic drive_px(input int v);
    @(negedge clk);
    bus.p_valid = 1'b1;
    bus.p_in    = PW'(v);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.p_valid = 1'b0;
    end
  endtask

  task automatic send_one(input int v, input int exp);
    drive_px(v);
    idle(2);
    check("latency_early", int'(bus.dout_valid), 0);
    idle(1);
    check("latency_valid", int'(bus.dout_valid), 1);
    check("pixel_value", int'(bus.dout), exp);
  endtask

  int rin[7] = '{12800, 12863, 12864, -500, 40000, 32703, -20000};
`ifdef DSP_PACK_SIGNED_EN
  int rexp[7] = '{100, 100, 101, 252, 127, 127, 128};
`else
  int rexp[7] = '{100, 100, 101, 0, 255, 255, 0};
`endif

  initial begin
    rst = 1'b1;
    bus.p_valid    = 1'b0;
    bus.p_in       = '0;
    bus.dout_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_count", int'(bus.count), 0);
    check("rst_dout_valid", int'(bus.dout_valid), 0);
    check("rst_dout", int'(bus.dout), 0);
    check("rst_overflow", int'(bus.overflow), 0);
    check("rst_almost_full", int'(bus.almost_full), 0);

    // Rounding and clamp, one result at a time
    bus.dout_ready = 1'b1;
    for (int i = 0; i < 7; i++) send_one(rin[i], rexp[i]);
    idle(2);

    // Fill to full, then drop one
    bus.dout_ready = 1'b0;
    for (int k = 0; k < 16; k++) drive_px(128 * k);
    idle(3);
    check("fill_count", int'(bus.count), 16);
    check("fill_overflow", int'(bus.overflow), 0);
    check("fill_almost_full", int'(bus.almost_full), 1);
    drive_px(128 * 16);
    idle(3);
    check("drop_overflow", int'(bus.overflow), 1);
    check("drop_count", int'(bus.count), 16);
    bus.dout_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("drain_valid", int'(bus.dout_valid), 1);
      check("drain_order", int'(bus.dout), k);
      idle(1);
    end
    check("drained_count", int'(bus.count), 0);
    check("drained_valid", int'(bus.dout_valid), 0);
    check("drained_hold", int'(bus.dout), 15);
    check("sticky_overflow", int'(bus.overflow), 1);
    check("drained_almost_full", int'(bus.almost_full), 0);

    // Reset with 5 stored and 2 in flight
    bus.dout_ready = 1'b0;
    for (int k = 0; k < 5; k++) drive_px(128 * (20 + k));
    idle(3);
    check("pre_rst_count", int'(bus.count), 5);
    drive_px(128 * 30);
    drive_px(128 * 31);
    @(negedge clk);
    bus.p_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_count", int'(bus.count), 0);
    check("midrst_valid", int'(bus.dout_valid), 0);
    check("midrst_overflow", int'(bus.overflow), 0);
    check("midrst_almost_full", int'(bus.almost_full), 0);
    for (int c = 0; c < 5; c++) begin
      idle(1);
      check("postrst_valid", int'(bus.dout_valid), 0);
      check("postrst_count", int'(bus.count), 0);
    end

    // Full FIFO with push and pop on the same edge
    for (int k = 0; k < 16; k++) drive_px(128 * k);
    idle(3);
    check("full2_count", int'(bus.count), 16);
    drive_px(128 * 40);
    idle(1);
    @(negedge clk);
    bus.dout_ready = 1'b1;
    @(negedge clk);
    check("pushpop_full_count", int'(bus.count), 16);
    check("pushpop_full_overflow", int'(bus.overflow), 0);
    for (int k = 1; k < 16; k++) begin
      check("pushpop_drain", int'(bus.dout), k);
      idle(1);
    end
    check("pushpop_tail", int'(bus.dout), 40);
    idle(1);
    check("pushpop_empty", int'(bus.count), 0);

    // Empty FIFO, consumer always ready
    drive_px(128 * 20);
    idle(3);
    check("empty_pp_valid", int'(bus.dout_valid), 1);
    check("empty_pp_dout", int'(bus.dout), 20);
    check("empty_pp_count", int'(bus.count), 1);
    idle(1);
    check("empty_pp_gone", int'(bus.dout_valid), 0);
    check("empty_pp_count0", int'(bus.count), 0);
    check("empty_pp_hold", int'(bus.dout), 20);

    // Randomized traffic with bursts of back-pressure and rare resets
    for (int i = 0; i < 3000; i++) begin
      int val;
      int sel;
      @(negedge clk);
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       val = int'($urandom) >>> 8;
        3:       val = 128 * int'($urandom_range(0, 255)) + int'($urandom_range(0, 4)) + 62;
        default: val = int'($urandom_range(0, 70000)) - 20000;
      endcase
      bus.p_valid = ($urandom_range(0, 2) != 0);
      bus.p_in    = PW'(val);
      if (((i / 150) % 3) == 0) bus.dout_ready = ($urandom_range(0, 7) == 0);
      else                      bus.dout_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.p_valid = 1'b0;
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
